msk_gfmul_hpc3_pipe: RTL

Masked HPC3 multiplier over GF(2^W) with NLANES independent lanes, d shares, and parametric field polynomial. It generalises the fixed GF(16) HPC3 gadget with four additions: a stored copy of operand a (no external a_prev port), a valid/ready handshake with back-pressure, reset, and a randomness-consumption strobe. It sits in masked S-box datapaths (inversion chains, AES/SKINNY-style S-boxes) where stalls from upstream or downstream are possible.

---
 rtl/msk_gfmul_hpc3_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/msk_gfmul_hpc3_pipe.sv
// Masked HPC3 GF(2^W) multiplier, NLANES lanes, d shares, 1-cycle latency.
// Ports: clk, rst (async high), in_valid/in_ready, ina, inb, rnd, rnd_ack,
//   out_valid/out_ready, out. Share bit index ((lane*W)+bit)*d+share.
// Option: MSKGFMUL_ZEROIZE_EN clears share registers when a result
//   is consumed and nothing new is accepted.
module msk_gfmul_hpc3_pipe #(
  parameter int d = 2,
  parameter int W = 4,
  parameter logic [W-1:0] POLY = 4'h3,
  parameter int NLANES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [NLANES*W*d-1:0] ina,
  input  logic [NLANES*W*d-1:0] inb,
  input  logic [NLANES*W*d*(d-1)-1:0] rnd,
  output logic rnd_ack,
  output logic out_valid,
  input  logic out_ready,
  output logic [NLANES*W*d-1:0] out
);

  function automatic logic [W-1:0] gf_mul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W-1:0] p;
    p = '0;
    for (int n = W-1; n >= 0; n--) begin
      p = {p[W-2:0], 1'b0} ^ (p[W-1] ? POLY : '0);
      if (y[n]) p = p ^ x;
    end
    return p;
  endfunction

  // index of pair (i,j), i<j, in lexicographic order
  function automatic int pidx(input int i, input int j);
    int p;
    p = 0;
    for (int k = 0; k < i; k++) p += d - 1 - k;
    return p + j - i - 1;
  endfunction

  logic accept;
  logic clr;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~rst;
  assign rnd_ack  = accept;

`ifdef MSKGFMUL_ZEROIZE_EN
  assign clr = out_valid & out_ready & ~accept;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else if (accept) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic [W-1:0] a_s [d];
    logic [W-1:0] b_s [d];

    for (genvar i = 0; i < d; i++) begin : g_sh
      logic [W-1:0] a_q;
      logic [W-1:0] acc;
      logic [W-1:0] term [d-1];

      for (genvar n = 0; n < W; n++) begin : g_bit
        assign a_s[i][n] = ina[((l*W)+n)*d+i];
        assign b_s[i][n] = inb[((l*W)+n)*d+i];
        assign out[((l*W)+n)*d+i] = acc[n];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) a_q <= '0;
        else if (accept) a_q <= a_s[i];
        else if (clr) a_q <= '0;
      end

      // k enumerates the partners j != i; k == 0 is the first one
      for (genvar k = 0; k < d-1; k++) begin : g_pair
        localparam int J  = (k < i) ? k : k + 1;
        localparam int P  = (i < J) ? pidx(i, J) : pidx(J, i);
        localparam int RB = l*W*d*(d-1) + P*2*W;
        logic [W-1:0] r0, r1, u_q, v_q, u_d;

        assign r0 = rnd[RB +: W];
        assign r1 = rnd[RB+W +: W];

        // first partner carries the a_i*b_i term
        if (k == 0) begin : g_first
          assign u_d = gf_mul(a_s[i], b_s[i] ^ r0) ^ r1;
        end else begin : g_rest
          assign u_d = gf_mul(a_s[i], r0) ^ r1;
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            u_q <= '0;
            v_q <= '0;
          end else if (accept) begin
            u_q <= u_d;
            v_q <= b_s[J] ^ r0;
          end else if (clr) begin
            u_q <= '0;
            v_q <= '0;
          end
        end

        assign term[k] = u_q ^ gf_mul(a_q, v_q);
      end

      always_comb begin
        acc = '0;
        for (int k = 0; k < d-1; k++) acc = acc ^ term[k];
      end
    end
  end

endmodule
